// File: rtl/secuenciador_sumador16.sv
// Multi-cycle add/sub/clear controller that drives a shared registered 4-bit adder
// one nibble at a time, LSB first, with the carry chained between nibbles.
module secuenciador_sumador16 #(
    parameter int unsigned NIB = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [4*NIB-1:0] X,
    input  logic [4*NIB-1:0] Y,
    output logic             BUSY,
    output logic             DONE,
    output logic [4*NIB-1:0] R,
    output logic             COUT,
    output logic             OVF,
    output logic             ADD_ENB,
    output logic [1:0]       ADD_MODO,
    output logic             ADD_RCI,
    output logic [3:0]       ADD_A,
    output logic [3:0]       ADD_B,
    input  logic [3:0]       ADD_Q,
    input  logic             ADD_RCO
);

    localparam int unsigned W  = 4 * NIB;
    localparam int unsigned IW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        CAP,
        CLR,
        FIN
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            c_q, c_d;
    logic [W-1:0]    xs_q, xs_d;
    logic [W-1:0]    ys_q, ys_d;
    logic [W-1:0]    s_q, s_d;
    logic [W-1:0]    r_q, r_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic [IW+1:0]   base;

    assign base = {idx_q, 2'b00};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            idx_q   <= '0;
            c_q     <= 1'b0;
            xs_q    <= '0;
            ys_q    <= '0;
            s_q     <= '0;
            r_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            s_q     <= s_d;
            r_q     <= r_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        c_d      = c_q;
        xs_d     = xs_q;
        ys_d     = ys_q;
        s_d      = s_q;
        r_d      = r_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        ADD_ENB  = 1'b0;
        ADD_MODO = 2'b00;
        ADD_RCI  = 1'b0;
        ADD_A    = 4'h0;
        ADD_B    = 4'h0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    // Subtraction runs as X + ~Y + 1: the +1 enters as the first carry-in.
                    xs_d  = X;
                    ys_d  = OP[0] ? ~Y : Y;
                    idx_d = '0;
                    c_d   = OP[0];
                    case (OP)
                        2'b00, 2'b01: state_d = RUN;
                        2'b10:        state_d = CLR;
                        default:      state_d = FIN;
                    endcase
                end
            end
            RUN: begin
                ADD_ENB  = 1'b1;
                ADD_MODO = 2'b01;
                ADD_A    = xs_q[base +: 4];
                ADD_B    = ys_q[base +: 4];
                ADD_RCI  = c_q;
                state_d  = CAP;
            end
            CAP: begin
                s_d[base +: 4] = ADD_Q;
                c_d            = ADD_RCO;
                if (idx_q == IW'(NIB - 1)) begin
                    // Results are loaded on the edge entering FIN so they are valid with DONE.
                    r_d     = s_d;
                    cout_d  = ADD_RCO;
                    ovf_d   = (xs_q[W-1] == ys_q[W-1]) && (s_d[W-1] != xs_q[W-1]);
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = RUN;
                end
            end
            CLR: begin
                ADD_ENB  = 1'b1;
                ADD_MODO = 2'b11;
                s_d      = '0;
                c_d      = 1'b0;
                r_d      = '0;
                cout_d   = 1'b0;
                ovf_d    = 1'b0;
                state_d  = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign BUSY = (state_q != IDLE);
    assign DONE = (state_q == FIN);
    assign R    = r_q;
    assign COUT = cout_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_secuenciador_sumador16.sv
// Bench for secuenciador_sumador16: behavioural 4-bit adder plus an arithmetic
// reference model of the 16-bit results, latency and adder-port behaviour.
module tb_secuenciador_sumador16;

    localparam int unsigned NIB = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [1:0]  OP;
    logic [15:0] X, Y;
    logic        BUSY, DONE;
    logic [15:0] R;
    logic        COUT, OVF;
    logic        ADD_ENB;
    logic [1:0]  ADD_MODO;
    logic        ADD_RCI;
    logic [3:0]  ADD_A, ADD_B;
    logic [3:0]  ADD_Q = 4'h0;
    logic        ADD_RCO = 1'b0;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int modo11_cnt = 0;
    int modo10_cnt = 0;
    logic [31:0] rci_log = '0;

    logic [15:0] er;
    logic        ec, eo;

    secuenciador_sumador16 #(.NIB(NIB)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .X(X), .Y(Y),
        .BUSY(BUSY), .DONE(DONE), .R(R), .COUT(COUT), .OVF(OVF),
        .ADD_ENB(ADD_ENB), .ADD_MODO(ADD_MODO), .ADD_RCI(ADD_RCI),
        .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_Q(ADD_Q), .ADD_RCO(ADD_RCO)
    );

    always #5 CLK = ~CLK;

    // External registered adder, never reset.
    always @(posedge CLK) begin
        if (ADD_ENB) begin
            case (ADD_MODO)
                2'b01:   {ADD_RCO, ADD_Q} <= {1'b0, ADD_A} + {1'b0, ADD_B} + {4'b0, ADD_RCI};
                2'b10:   {ADD_RCO, ADD_Q} <= {1'b0, ADD_A} - {1'b0, ADD_B};
                2'b11:   ADD_Q <= 4'h0;
                default: ;
            endcase
        end
    end

    always @(negedge CLK) begin
        if (DONE) done_cnt++;
        if (ADD_ENB && ADD_MODO == 2'b11) modo11_cnt++;
        if (ADD_MODO == 2'b10) modo10_cnt++;
        if (ADD_ENB && ADD_MODO == 2'b01) rci_log = {rci_log[30:0], ADD_RCI};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        case (op)
            2'b00: begin
                s  = {1'b0, x} + {1'b0, y};
                er = s[15:0];
                ec = s[16];
                eo = (x[15] == y[15]) && (er[15] != x[15]);
            end
            2'b01: begin
                er = x - y;
                ec = (x >= y);
                eo = (x[15] != y[15]) && (er[15] != x[15]);
            end
            2'b10: begin
                er = 16'h0;
                ec = 1'b0;
                eo = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                          input bit poke, input string tag);
        int lat;
        int el;
        int d0;
        int m0;
        model(op, x, y);
        el = (op < 2) ? 2 * NIB + 1 : ((op == 2) ? 2 : 1);
        d0 = done_cnt;
        m0 = modo11_cnt;
        @(negedge CLK);
        START = 1'b1; OP = op; X = x; Y = y;
        @(posedge CLK);
        #1;
        START = 1'b0;
        OP = 2'($urandom_range(3));
        X  = 16'($urandom);
        Y  = 16'($urandom);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge CLK);
            if (n == 1) chk({tag, "_busy"}, 32'(BUSY), 32'(1));
            START = (poke && n == 2);
            if (DONE) begin
                lat = n;
                break;
            end
        end
        START = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(el));
        chk({tag, "_R"}, 32'(R), 32'(er));
        chk({tag, "_COUT"}, 32'(COUT), 32'(ec));
        chk({tag, "_OVF"}, 32'(OVF), 32'(eo));
        if (op == 2) chk({tag, "_modo11_cycles"}, 32'(modo11_cnt - m0), 32'(1));
        @(negedge CLK);
        chk({tag, "_idle_after"}, 32'({BUSY, DONE}), 32'(0));
        repeat (3) @(negedge CLK);
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'(1));
    endtask

    initial begin
        RESET = 1'b0; START = 1'b0; OP = 2'b00; X = '0; Y = '0;
        er = '0; ec = 1'b0; eo = 1'b0;

        // Asynchronous reset mid-cycle, then held.
        repeat (2) @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        chk("rst_async", 32'({BUSY, DONE, R, COUT, OVF, ADD_ENB, ADD_MODO, ADD_RCI, ADD_A, ADD_B}), 32'(0));
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_held", 32'({BUSY, DONE, R, COUT, OVF, ADD_ENB, ADD_MODO, ADD_RCI, ADD_A, ADD_B}), 32'(0));
        @(negedge CLK);
        RESET = 1'b0;

        rci_log = '0;
        run_op(2'b00, 16'h1234, 16'h0FCD, 1'b0, "add_ripple");
        chk("add_ripple_R_const", 32'(R), 32'h2201);
        chk("add_ripple_rci_seq", 32'(rci_log[3:0]), 32'(4'b0111));

        run_op(2'b00, 16'hFFFF, 16'h0001, 1'b0, "add_fullcarry");
        chk("add_fullcarry_const", 32'({R, COUT, OVF}), 32'({16'h0000, 1'b1, 1'b0}));
        run_op(2'b00, 16'h7FFF, 16'h0001, 1'b0, "add_ovf");
        chk("add_ovf_const", 32'({R, COUT, OVF}), 32'({16'h8000, 1'b0, 1'b1}));

        run_op(2'b01, 16'h0003, 16'h0005, 1'b0, "sub_borrow");
        chk("sub_borrow_const", 32'({R, COUT, OVF}), 32'({16'hFFFE, 1'b0, 1'b0}));
        run_op(2'b01, 16'h8000, 16'h0001, 1'b0, "sub_ovf");
        chk("sub_ovf_const", 32'({R, COUT, OVF}), 32'({16'h7FFF, 1'b1, 1'b1}));

        run_op(2'b00, 16'h1234, 16'h0FCD, 1'b0, "add_pre_clear");
        run_op(2'b10, 16'hABCD, 16'h1111, 1'b0, "clear");

        run_op(2'b00, 16'h4321, 16'h1111, 1'b1, "add_ignore_start");
        run_op(2'b11, 16'h9999, 16'h1111, 1'b0, "noop");

        // Reset four edges into an add.
        @(negedge CLK);
        START = 1'b1; OP = 2'b00; X = 16'h1111; Y = 16'h2222;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (4) @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("midop_rst", 32'({BUSY, ADD_ENB, R}), 32'(0));
        er = '0; ec = 1'b0; eo = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        run_op(2'b00, 16'h0001, 16'h0002, 1'b0, "add_after_rst");

        for (int k = 0; k < 24; k++) begin
            run_op(2'($urandom_range(3)), 16'($urandom), 16'($urandom), bit'($urandom_range(1)), "rand");
        end

        chk("modo10_never", 32'(modo10_cnt), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
